// File: rtl/unary_add_nch.sv
// rtl/unary_add_nch.sv - N-lane unary pulse-count accumulator with serial unary readback
// Optional UNARY_ADD_SAT_EN: accumulate saturates at the maximum count instead of wrapping.
module unary_add_nch #(
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              mode,
    input  logic [NUM_IN-1:0] din,
    output logic              dout,
    output logic              carry,
    output logic              ovf,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PC_W = $clog2(NUM_IN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count, count_nx;
    logic             dout_nx, carry_nx, ovf_nx, done_nx;
    logic [PC_W-1:0]  pc;
    logic [CNT_W:0]   sum;

    always_comb begin
        pc = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            pc = pc + PC_W'(din[i]);
        end
        sum = {1'b0, count} + (CNT_W + 1)'(pc);
    end

    always_comb begin
        count_nx = count;
        dout_nx  = dout;
        ovf_nx   = ovf;
        carry_nx = 1'b0;
        done_nx  = 1'b0;
        if (clr) begin
            count_nx = '0;
            ovf_nx   = 1'b0;
            dout_nx  = 1'b0;
        end else if (en) begin
            if (!mode) begin
                carry_nx = sum[CNT_W];
                ovf_nx   = ovf | sum[CNT_W];
                dout_nx  = 1'b0;
`ifdef UNARY_ADD_SAT_EN
                count_nx = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
`else
                count_nx = sum[CNT_W-1:0];
`endif
            end else if (count != '0) begin
                dout_nx  = 1'b1;
                count_nx = count - 1'b1;
                done_nx  = (count == CNT_W'(1));
            end else begin
                dout_nx  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            dout  <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= count_nx;
            dout  <= dout_nx;
            carry <= carry_nx;
            ovf   <= ovf_nx;
            done  <= done_nx;
        end
    end

    assign count_o = count;
    assign busy    = mode && (count != '0);
endmodule

// File: tb/tb_unary_add_nch.sv
// tb/tb_unary_add_nch.sv - scoreboard bench for unary_add_nch (2x4 and 8x6 instances)
module tb_unary_add_nch;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, mode;
    logic [1:0] din;
    logic       dout, carry, ovf, done, busy;
    logic [3:0] count_o;

    logic       en8, clr8, mode8;
    logic [7:0] din8;
    logic       dout8, carry8, ovf8, done8, busy8;
    logic [5:0] count8;

    int n_vec  = 0;
    int n_miss = 0;
    int ones   = 0;
    int dones  = 0;

    logic [3:0] m_count;
    logic       m_dout, m_carry, m_ovf, m_done;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    unary_add_nch #(.NUM_IN(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .din(din),
        .dout(dout), .carry(carry), .ovf(ovf), .done(done), .busy(busy), .count_o(count_o)
    );

    unary_add_nch #(.NUM_IN(8), .CNT_W(6)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .clr(clr8), .mode(mode8), .din(din8),
        .dout(dout8), .carry(carry8), .ovf(ovf8), .done(done8), .busy(busy8), .count_o(count8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = '0; m_dout = 1'b0; m_carry = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
    endtask

    task automatic step(input logic e, input logic c, input logic m, input logic [1:0] d);
        logic [4:0] s;
        logic [8:0] ex;
        @(negedge clk);
        en = e; clr = c; mode = m; din = d;
        if (c) begin
            m_count = '0; m_ovf = 1'b0; m_dout = 1'b0; m_carry = 1'b0; m_done = 1'b0;
        end else if (!e) begin
            m_carry = 1'b0; m_done = 1'b0;
        end else if (!m) begin
            s = {1'b0, m_count} + 5'(d[0]) + 5'(d[1]);
            m_carry = s[4];
            m_ovf   = m_ovf | s[4];
`ifdef UNARY_ADD_SAT_EN
            m_count = s[4] ? 4'hF : s[3:0];
`else
            m_count = s[3:0];
`endif
            m_dout = 1'b0; m_done = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (m_count != 0) begin
                m_done  = (m_count == 4'd1);
                m_dout  = 1'b1;
                m_count = m_count - 4'd1;
            end else begin
                m_dout = 1'b0; m_done = 1'b0;
            end
        end
        sb.push_back({m_count, m_dout, m_carry, m_ovf, m_done, (m && m_count != 0)});
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        check("count_o", 32'(count_o), 32'(ex[8:5]));
        check("dout",    32'(dout),    32'(ex[4]));
        check("carry",   32'(carry),   32'(ex[3]));
        check("ovf",     32'(ovf),     32'(ex[2]));
        check("done",    32'(done),    32'(ex[1]));
        check("busy",    32'(busy),    32'(ex[0]));
        if (e && dout) ones++;
        if (done) dones++;
    endtask

    initial begin
        rst_n = 1'b0; en = 0; clr = 0; mode = 0; din = '0;
        en8 = 0; clr8 = 0; mode8 = 0; din8 = '0;
        model_reset();
        #2;
        check("rst_count", 32'(count_o), 0);
        check("rst_flags", 32'({dout, carry, ovf, done, busy}), 0);
        #10 rst_n = 1'b1;

        // accumulate to 7, then drain over 8 emit cycles
        repeat (3) step(1, 0, 0, 2'b11);
        step(1, 0, 0, 2'b01);
        check("acc7", 32'(count_o), 7);
        ones = 0; dones = 0;
        repeat (8) step(1, 0, 1, 2'b00);
        check("emit7_ones", 32'(ones), 7);
        check("emit7_done", 32'(dones), 1);

        // overflow at 14+2, sticky ovf, then count=max with pc=0 and pc=1
        repeat (7) step(1, 0, 0, 2'b11);
        step(1, 0, 0, 2'b11);
        step(1, 0, 0, 2'b00);
        step(0, 0, 0, 2'b11);
        while (m_count < 4'd15) step(1, 0, 0, 2'b01);
        step(1, 0, 0, 2'b00);
        step(1, 0, 0, 2'b01);
        step(0, 1, 0, 2'b00);

        // gated emit of 4
        repeat (2) step(1, 0, 0, 2'b11);
        ones = 0; dones = 0;
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(1, 0, 1, 0);
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(1, 0, 1, 0);
        repeat (2) step(1, 0, 1, 0);
        check("gated_ones", 32'(ones), 4);
        check("gated_done", 32'(dones), 1);

        // interrupted emit keeps the residual count
        step(1, 0, 0, 2'b11); step(1, 0, 0, 2'b01);
        step(1, 0, 1, 0);
        step(1, 0, 0, 2'b01);
        repeat (4) step(1, 0, 1, 0);

        // clr beats an enabled accumulate with count=9, ovf=1
        repeat (8) step(1, 0, 0, 2'b11);
        while (m_count > 4'd9) step(1, 0, 1, 0);
        while (m_count < 4'd9) step(1, 0, 0, 2'b01);
        check("pre_clr_ovf", 32'(ovf), 1);
        step(1, 1, 0, 2'b11);
        check("clr_count", 32'(count_o), 0);

        // asynchronous reset in the middle of an emit
        repeat (3) step(1, 0, 0, 2'b11);
        step(1, 0, 1, 0);
        check("pre_rst_count", 32'(count_o), 5);
        @(negedge clk);
        en = 1; mode = 1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_count", 32'(count_o), 0);
        check("arst_flags", 32'({dout, carry, ovf, done, busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 2'b10);

        // 8-lane, 6-bit instance
        en = 0;
        repeat (7) begin
            @(negedge clk); en8 = 1; din8 = 8'hFF;
            @(posedge clk); #1;
        end
        check("w8_count56", 32'(count8), 56);
        check("w8_nocarry", 32'(carry8), 0);
        @(negedge clk); din8 = 8'hFF;
        @(posedge clk); #1;
        check("w8_carry", 32'(carry8), 1);
        check("w8_ovf", 32'(ovf8), 1);
`ifdef UNARY_ADD_SAT_EN
        check("w8_count_ovf", 32'(count8), 63);
`else
        check("w8_count_ovf", 32'(count8), 0);
`endif
        @(negedge clk); en8 = 0;
        @(posedge clk); #1;
        check("w8_carry_off", 32'(carry8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
